traverse_engine: RTL
====================

# traverse_engine

Execution-side responder to the accelerator's 3-bit phase bus. It decodes the broadcast phase (IDLE, GET_PARAM, GET_DATA, EX, WRIT_PRE, WRITE_BACK, DONE) and performs the matching action for one element per loop:

- latch parameters
- read a source word
- scale and bias it
- saturate it
- write it to the destination

It counts processed elements and raises `finish` back to the phase controller when the traversal length is exhausted.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 16, signed sample width
- LEN_W, 10, element-count width
- SHIFT, 4, arithmetic right shift applied to the product

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- state  in  3  phase code from controller: 000 IDLE, 001 GET_PARAM, 010 GET_DATA, 011 EX, 100 WRIT_PRE, 101 WRITE_BACK, 110 DONE, 111 unused
- cfg_src  in  ADDR_W  source base address
- cfg_dst  in  ADDR_W  destination base address
- cfg_len  in  LEN_W  number of elements
- cfg_gain  in  DATA_W  signed multiplier
- cfg_bias  in  DATA_W  signed offset
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid one cycle after mem_rd_en (synchronous RAM)
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_W  write data
- finish  out  1  traversal complete, sticky until reset
- sat_cnt  out  LEN_W  count of saturated results

## Operation
- **Reset (rst_n=0 at an edge)** clears all of the following; applies mid-traversal too, discarding the in-flight element:
  - idx, loaded, product reg, wr_data/wr_addr regs, finish, sat_cnt
  - all outputs read 0 during and after reset until a phase acts
- **Global gate.** `act = !finish && state != 110 && state != 111`. When `act=0`, no strobe is asserted and no register changes except by reset.
- **GET_PARAM.**
  - If `loaded=0`: latch all cfg_* and set `loaded=1`.
  - If the latched `cfg_len` is 0, set `finish` at the same edge.
  - Later GET_PARAM cycles hold the latched values; cfg_* changes are ignored until reset.
- **GET_DATA** (requires `loaded`):
  - `mem_rd_en=1` combinationally.
  - `mem_rd_addr = (src + idx) mod 2^ADDR_W`.
- **EX.** Register `prod = (mem_rd_data * gain) >>> SHIFT`:
  - full 2*DATA_W signed product
  - arithmetic shift
- **WRIT_PRE.**
  - Compute `sum = prod + bias`, sign-extended to 2*DATA_W+1 bits.
  - Saturate to `[-2^(DATA_W-1), 2^(DATA_W-1)-1]`.
  - Register the result into wr_data.
  - Register `wr_addr = (dst + idx) mod 2^ADDR_W`.
  - If clipped, `sat_cnt++`; it saturates at all-ones and does not wrap.
- **WRITE_BACK.**
  - `mem_wr_en=1` combinationally, with `mem_wr_addr`/`mem_wr_data` driven from the registers.
  - At the edge, `idx++`.
  - If `idx+1 == len`, set `finish`.
- **IDLE, DONE, 111:** no action.
- **Out-of-order or repeated phases:** each phase still performs only its own action (e.g. a repeated WRITE_BACK writes the same data again and increments idx).
- mem_rd_addr and mem_wr_addr/mem_wr_data hold their last values when not strobed.
- The strobes are the only qualifiers.

## Timing
- The controller holds each phase exactly 1 cycle; one element costs 5 cycles (GET_PARAM through WRITE_BACK).
- Cycle n GET_DATA: rd_en high. Cycle n+1 EX: mem_rd_data valid and sampled. Cycle n+2 WRIT_PRE: result registered. Cycle n+3 WRITE_BACK: wr_en high.
- `finish` rises on the clock edge that ends the last WRITE_BACK. It is high in the following cycle, when state is GET_PARAM and `act=0`. The controller enters DONE on the next edge.
- For `len=0`, `finish` rises at the edge ending the first GET_PARAM. No read or write ever occurs.
- Strobes are combinational from `state` and registered flags; there are no paths from mem_rd_data to outputs.

## Test plan
- **Normal traversal.**
  - Stimulus: src=0x010, dst=0x100, len=3, gain=16, bias=0, SHIFT=4, memory[0x10..0x12]={5,-7,100}.
  - Required: writes {5,-7,100} to 0x100..0x102, exactly 3 wr_en pulses, finish high 1 cycle after the third WRITE_BACK, then state reaches DONE; sat_cnt=0.
- **Zero length.**
  - Stimulus: len=0.
  - Required: finish high the cycle after GET_PARAM; mem_rd_en and mem_wr_en never asserted.
- **Saturation.**
  - Stimulus: gain=0x7FFF, bias=0x7FFF, data {0x7FFF, 0x8000}, len=2.
  - Required: written {0x7FFF, 0x8000}; sat_cnt=2.
- **Address wrap.**
  - Stimulus: src=0x3FE, dst=0x3FF, len=3.
  - Required: reads 0x3FE, 0x3FF, 0x000; writes 0x3FF, 0x000, 0x001.
- **Reset mid-op.**
  - Stimulus: assert rst_n=0 during EX of element 1, then restart with new cfg_len=2.
  - Required: all outputs 0; new params latched; exactly 2 writes.
- **Post-finish and illegal states.**
  - Stimulus: drive state 010, 101, 111 after finish is set.
  - Required: no strobes; idx and sat_cnt unchanged.

Source files
------------

// File: rtl/traverse_engine.sv
// Execution-side responder to the accelerator phase bus: for each element it reads a
// source word, scales, biases and saturates it, then writes it to the destination.
module traverse_engine #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        state,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] cfg_gain,
  input  logic [DATA_W-1:0] cfg_bias,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              finish,
  output logic [LEN_W-1:0]  sat_cnt
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PROD_W + 1;
  localparam int unsigned CNT_W  = LEN_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]       OUT_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       OUT_LO = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    PH_IDLE       = 3'b000,
    PH_GET_PARAM  = 3'b001,
    PH_GET_DATA   = 3'b010,
    PH_EX         = 3'b011,
    PH_WRIT_PRE   = 3'b100,
    PH_WRITE_BACK = 3'b101,
    PH_DONE       = 3'b110,
    PH_RSVD       = 3'b111
  } phase_e;

  logic                     loaded_q, loaded_d;
  logic [ADDR_W-1:0]        src_q, src_d;
  logic [ADDR_W-1:0]        dst_q, dst_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [DATA_W-1:0]        gain_q, gain_d;
  logic [DATA_W-1:0]        bias_q, bias_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;
  logic                     finish_q, finish_d;
  logic [LEN_W-1:0]         sat_cnt_q, sat_cnt_d;

  phase_e                   phase_c;
  logic                     act_c;
  logic                     rd_en_c;
  logic                     wr_en_c;
  logic                     clip_c;
  logic [ADDR_W-1:0]        src_idx_c;
  logic [ADDR_W-1:0]        dst_idx_c;
  logic signed [PROD_W-1:0] mult_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic [CNT_W-1:0]         idx_next_c;

  // Element datapath: addresses wrap at the address width, product is full precision.
  assign src_idx_c  = src_q + ADDR_W'(idx_q);
  assign dst_idx_c  = dst_q + ADDR_W'(idx_q);
  assign mult_c     = PROD_W'($signed(mem_rd_data)) * PROD_W'($signed(gain_q));
  assign sum_c      = SUM_W'(prod_q) + SUM_W'($signed(bias_q));
  assign idx_next_c = CNT_W'(idx_q) + CNT_W'(1);

  assign phase_c = phase_e'(state);
  assign act_c   = rst_n && !finish_q && (phase_c != PH_DONE) && (phase_c != PH_RSVD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded_q  <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      gain_q    <= '0;
      bias_q    <= '0;
      idx_q     <= '0;
      prod_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      finish_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      loaded_q  <= loaded_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      gain_q    <= gain_d;
      bias_q    <= bias_d;
      idx_q     <= idx_d;
      prod_q    <= prod_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      finish_q  <= finish_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // Phase decode: each phase performs only its own action, and only while active.
  always_comb begin
    loaded_d  = loaded_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    gain_d    = gain_q;
    bias_d    = bias_q;
    idx_d     = idx_q;
    prod_d    = prod_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    finish_d  = finish_q;
    sat_cnt_d = sat_cnt_q;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    clip_c    = 1'b0;

    if (act_c) begin
      case (phase_c)
        PH_GET_PARAM: begin
          if (!loaded_q) begin
            loaded_d = 1'b1;
            src_d    = cfg_src;
            dst_d    = cfg_dst;
            len_d    = cfg_len;
            gain_d   = cfg_gain;
            bias_d   = cfg_bias;
            if (cfg_len == '0) begin
              finish_d = 1'b1;
            end
          end
        end
        PH_GET_DATA: begin
          if (loaded_q) begin
            rd_en_c   = 1'b1;
            rd_addr_d = src_idx_c;
          end
        end
        PH_EX: begin
          if (loaded_q) begin
            prod_d = mult_c >>> SHIFT;
          end
        end
        PH_WRIT_PRE: begin
          if (loaded_q) begin
            wr_addr_d = dst_idx_c;
            if (sum_c > SAT_HI) begin
              wr_data_d = OUT_HI;
              clip_c    = 1'b1;
            end else if (sum_c < SAT_LO) begin
              wr_data_d = OUT_LO;
              clip_c    = 1'b1;
            end else begin
              wr_data_d = sum_c[DATA_W-1:0];
            end
            // Clip counter sticks at all-ones rather than wrapping.
            if (clip_c && (sat_cnt_q != '1)) begin
              sat_cnt_d = sat_cnt_q + LEN_W'(1);
            end
          end
        end
        PH_WRITE_BACK: begin
          if (loaded_q) begin
            wr_en_c = 1'b1;
            idx_d   = idx_q + LEN_W'(1);
            if (idx_next_c == CNT_W'(len_q)) begin
              finish_d = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_rd_en   = rd_en_c;
  assign mem_rd_addr = rd_en_c ? src_idx_c : rd_addr_q;
  assign mem_wr_en   = wr_en_c;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign finish      = finish_q;
  assign sat_cnt     = sat_cnt_q;

endmodule
